wb_select_stage: RTL and testbench
==================================

Name: wb_select_stage

Overview:
Parametrised, registered successor to the write-back source multiplexer of the multi-cycle MIPS datapath. Selects one of N_SRC 32-bit (DATA_W) sources into a one-entry pipeline register with valid/ready handshake, stall hold, illegal-select detection and $zero write suppression. The stage sits between the datapath source registers (ALUOut, MDR, HI, LO, shifter, etc.) and the register-file write port. It also provides a forwarding output for the control unit.

Parameters:
DATA_W, 32, width of each source and of the write-back data
N_SRC, 9, number of selectable sources (at least 2)
SEL_W, $clog2(N_SRC), select width (derived; 4 at default)
ADDR_W, 5, register-file address width
ZERO_SUPPRESS, 1, when 1, a write to address 0 completes but does not assert rf_we

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
src_bus  input  N_SRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W]
sel  input  SEL_W  source index
in_dst  input  ADDR_W  destination register
in_valid  input  1  request is valid
in_ready  output  1  stage can accept a request
stall  input  1  downstream freeze; holds the output register
rf_we  output  1  register-file write enable, one-cycle pulse per accepted write
rf_addr  output  ADDR_W  registered destination
rf_data  output  DATA_W  registered selected data
fwd_addr  input  ADDR_W  forwarding query address
fwd_hit  output  1  combinational: the held entry is valid, fwd_addr equals rf_addr, and fwd_addr is not 0
fwd_data  output  DATA_W  equals rf_data when fwd_hit is 1, otherwise 0
sel_err  output  1  sticky illegal-select flag
wr_count  output  16  count of rf_we pulses, wraps modulo 2^16

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on reset. Reset has priority over every other input in the same cycle.
- Reset values: rf_we=0, rf_addr=0, rf_data=0, sel_err=0, wr_count=0, state=IDLE. in_ready=1 from the first cycle after reset.
- Handshake: in_ready = !stall.
  - A request is accepted on a rising edge when in_valid && in_ready.
  - Latency: accept in cycle t; rf_data, rf_addr and rf_we are visible in cycle t+1.
- Selection: rf_data <= src_bus[sel]. If sel >= N_SRC, rf_data <= 0 and sel_err sets; sel_err stays set until reset.
- FSM states:
  - IDLE: no entry is held.
  - WRITE: rf_we=1 for exactly one cycle.
  - HELD: entry is retained for forwarding, rf_we=0.
- FSM transitions:
  - IDLE -> WRITE on accept.
  - WRITE -> WRITE on a new accept (back-to-back, one accept per cycle). Otherwise WRITE -> HELD.
  - HELD -> WRITE on accept.
- Stall:
  - While stall=1, no accept occurs.
  - If stall rises while in WRITE, the pulse already issued completes. rf_we drops the next cycle, and rf_data and rf_addr hold.
  - stall never stretches rf_we.
- Zero suppression: when ZERO_SUPPRESS=1 and in_dst=0, the stage enters WRITE, but rf_we stays 0 and wr_count does not increment. rf_data and rf_addr still update.
- wr_count: increments on every cycle with rf_we=1. 16'hFFFF wraps to 0.
- Forwarding is combinational from registered state only; there is no combinational path from src_bus.
- Reset mid-operation: a pending WRITE is aborted, so no rf_we is issued in the cycle after reset.

Decomposition:
- Shared package wb_pkg holds:
  - WB_SRC_* index constants: ALUOUT=0, LOADSIZE=1, MEMDATA=2, RD=3, SE1_32=4, CONST227=5, REGB=6, HI=7, LO=8.
  - The FSM state typedef {IDLE, WRITE, HELD}.
  - Default DATA_W and ADDR_W.
- One natural sub-module, wb_src_select: purely combinational N-to-1 indexed select that also produces an illegal-select flag. It is instantiated once; the parent owns all registers.

Test Plan:
- Reset then accept sel=7 (HI=32'hDEAD_BEEF), in_dst=5 -> next cycle rf_we=1, rf_addr=5, rf_data=32'hDEAD_BEEF, wr_count=1; the cycle after, rf_we=0 and fwd_hit=1 for fwd_addr=5.
- Three back-to-back accepts with sel 0,2,8 -> three consecutive rf_we pulses carrying the matching sources in order; wr_count=3.
- Accept sel=4'hF with N_SRC=9 -> rf_data=0, sel_err=1; sel_err persists through later valid writes; reset clears it.
- in_dst=0 with ZERO_SUPPRESS=1 -> rf_we stays 0, wr_count unchanged, fwd_hit=0 for fwd_addr=0.
- stall=1 for 4 cycles with in_valid=1 -> in_ready=0 and no rf_we during the stall; rf_data and rf_addr hold; accept happens on the first cycle after stall falls.
- reset asserted in the same cycle as an accept -> next cycle all outputs equal their reset values, with no rf_we; wr_count wraps from 16'hFFFF to 0 after one further write (preloaded via force).

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back select stage: source indices,
// FSM state encoding and default widths.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   // Write-back source indices as wired on the datapath src_bus
   localparam int WB_SRC_ALUOUT   = 0;
   localparam int WB_SRC_LOADSIZE = 1;
   localparam int WB_SRC_MEMDATA  = 2;
   localparam int WB_SRC_RD       = 3;
   localparam int WB_SRC_SE1_32   = 4;
   localparam int WB_SRC_CONST227 = 5;
   localparam int WB_SRC_REGB     = 6;
   localparam int WB_SRC_HI       = 7;
   localparam int WB_SRC_LO       = 8;
   localparam int WB_N_SRC        = WB_SRC_LO + 1;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      HELD
   } wb_state_e;

endpackage

// File: rtl/wb_src_select.sv
// Combinational N-to-1 indexed source select; out-of-range indices give
// zero data and raise illegal_o.
module wb_src_select #(
   parameter int DATA_W = 32,
   parameter int N_SRC  = 9,
   parameter int SEL_W  = $clog2(N_SRC)
) (
   input  logic [N_SRC*DATA_W-1:0] src_bus_i,
   input  logic [SEL_W-1:0]        sel_i,
   output logic [DATA_W-1:0]       data_o,
   output logic                    illegal_o
);

   localparam logic [SEL_W:0] NSRC_C = (SEL_W + 1)'(N_SRC);

   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      data_o    = '0;
      illegal_o = ({1'b0, sel_i} >= NSRC_C);
      for (int k = 0; k < N_SRC; k++) begin
         if (sel_i == SEL_W'(k)) begin
            data_o = src_bus_i[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back source multiplexer: one-entry output register with
// valid/ready handshake, stall hold, sticky illegal-select flag and $zero suppression.
module wb_select_stage
   import wb_pkg::*;
#(
   parameter int DATA_W        = WB_DATA_W,
   parameter int N_SRC         = WB_N_SRC,
   parameter int SEL_W         = $clog2(N_SRC),
   parameter int ADDR_W        = WB_ADDR_W,
   parameter int ZERO_SUPPRESS = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_SRC*DATA_W-1:0] src_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic [ADDR_W-1:0]       in_dst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    stall,
   output logic                    rf_we,
   output logic [ADDR_W-1:0]       rf_addr,
   output logic [DATA_W-1:0]       rf_data,
   input  logic [ADDR_W-1:0]       fwd_addr,
   output logic                    fwd_hit,
   output logic [DATA_W-1:0]       fwd_data,
   output logic                    sel_err,
   output logic [15:0]             wr_count
);

   logic [DATA_W-1:0] sel_data;
   logic              sel_illegal;
   logic              accept;
   logic              dst_zero;

   wb_state_e         state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic [15:0]       cnt_q, cnt_d;

   wb_src_select #(
      .DATA_W (DATA_W),
      .N_SRC  (N_SRC),
      .SEL_W  (SEL_W)
   ) u_src_select (
      .src_bus_i (src_bus),
      .sel_i     (sel),
      .data_o    (sel_data),
      .illegal_o (sel_illegal)
   );

   assign in_ready = !stall;
   assign accept   = in_valid && !stall;
   assign dst_zero = (ZERO_SUPPRESS != 0) && (in_dst == '0);

   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         IDLE:    if (accept) state_d = WRITE;
         WRITE:   state_d = accept ? WRITE : HELD;
         HELD:    if (accept) state_d = WRITE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         we_d   = !dst_zero;
         addr_d = in_dst;
         data_d = sel_data;
         err_d  = err_q | sel_illegal;
      end
      // Count the pulse being scheduled so wr_count updates alongside rf_we.
      cnt_d = cnt_q + {15'd0, we_d};
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rf_we    = we_q;
   assign rf_addr  = addr_q;
   assign rf_data  = data_q;
   assign sel_err  = err_q;
   assign wr_count = cnt_q;

   // Forwarding looks only at registered state, never at src_bus.
   assign fwd_hit  = (state_q != IDLE) && (fwd_addr == addr_q) && (fwd_addr != '0);
   assign fwd_data = fwd_hit ? data_q : '0;

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: table-driven vectors with a
// scoreboard queue, plus hand-written stall, reset and wrap sequences.
module tb_wb_select_stage;

   localparam int DATA_W = 32;
   localparam int N_SRC  = 9;
   localparam int SEL_W  = 4;
   localparam int ADDR_W = 5;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [N_SRC*DATA_W-1:0] src_bus;
   logic [SEL_W-1:0]        sel;
   logic [ADDR_W-1:0]       in_dst;
   logic                    in_valid;
   logic                    in_ready;
   logic                    stall;
   logic                    rf_we;
   logic [ADDR_W-1:0]       rf_addr;
   logic [DATA_W-1:0]       rf_data;
   logic [ADDR_W-1:0]       fwd_addr;
   logic                    fwd_hit;
   logic [DATA_W-1:0]       fwd_data;
   logic                    sel_err;
   logic [15:0]             wr_count;

   wb_select_stage #(
      .DATA_W        (DATA_W),
      .N_SRC         (N_SRC),
      .SEL_W         (SEL_W),
      .ADDR_W        (ADDR_W),
      .ZERO_SUPPRESS (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .src_bus  (src_bus),
      .sel      (sel),
      .in_dst   (in_dst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .stall    (stall),
      .rf_we    (rf_we),
      .rf_addr  (rf_addr),
      .rf_data  (rf_data),
      .fwd_addr (fwd_addr),
      .fwd_hit  (fwd_hit),
      .fwd_data (fwd_data),
      .sel_err  (sel_err),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              valid;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] dst;
      logic [ADDR_W-1:0] fwd;
      logic              exp_we;
      logic              exp_hit;
   } vec_t;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              err;
      logic [15:0]       cnt;
   } exp_t;

   logic [DATA_W-1:0] src [N_SRC];
   vec_t              vecs [10];
   exp_t              sb [$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic              m_err;
   logic [15:0]       m_cnt;
   logic              m_held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_addr = '0;
      m_data = '0;
      m_err  = 1'b0;
      m_cnt  = '0;
      m_held = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_we"},    {31'd0, rf_we},   32'd0);
      check({tag, "_addr"},  {27'd0, rf_addr}, 32'd0);
      check({tag, "_data"},  rf_data,          32'd0);
      check({tag, "_err"},   {31'd0, sel_err}, 32'd0);
      check({tag, "_cnt"},   {16'd0, wr_count}, 32'd0);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   // Drive one cycle of stimulus, push the model's prediction, then compare.
   task automatic apply(input logic v, input logic s, input logic [SEL_W-1:0] sl,
                        input logic [ADDR_W-1:0] d, input string tag);
      exp_t e;
      exp_t got;
      logic acc;
      in_valid = v;
      stall    = s;
      sel      = sl;
      in_dst   = d;
      #1;
      check({tag, "_ready"}, {31'd0, in_ready}, {31'd0, !s});
      acc = v && !s;
      if (acc) begin
         m_addr = d;
         m_data = (sl < SEL_W'(N_SRC)) ? src[sl] : '0;
         m_err  = m_err | (sl >= SEL_W'(N_SRC));
         e.we   = (d != '0);
         m_cnt  = m_cnt + {15'd0, e.we};
         m_held = 1'b1;
      end else begin
         e.we = 1'b0;
      end
      e.addr = m_addr;
      e.data = m_data;
      e.err  = m_err;
      e.cnt  = m_cnt;
      sb.push_back(e);
      step();
      in_valid = 1'b0;
      stall    = 1'b0;
      got = sb.pop_front();
      check({tag, "_we"},   {31'd0, rf_we},    {31'd0, got.we});
      check({tag, "_addr"}, {27'd0, rf_addr},  {27'd0, got.addr});
      check({tag, "_data"}, rf_data,           got.data);
      check({tag, "_err"},  {31'd0, sel_err},  {31'd0, got.err});
      check({tag, "_cnt"},  {16'd0, wr_count}, {16'd0, got.cnt});
   endtask

   initial begin
      for (int k = 0; k < N_SRC; k++) src[k] = 32'h1111_1111 * (k + 1);
      src[7] = 32'hDEAD_BEEF;
      for (int k = 0; k < N_SRC; k++) src_bus[k*DATA_W +: DATA_W] = src[k];

      //           valid sel    dst    fwd    we    hit
      vecs[0] = '{1'b1, 4'd7, 5'd5,  5'd5,  1'b1, 1'b1};
      vecs[1] = '{1'b0, 4'd0, 5'd0,  5'd5,  1'b0, 1'b1};
      vecs[2] = '{1'b1, 4'd0, 5'd1,  5'd1,  1'b1, 1'b1};
      vecs[3] = '{1'b1, 4'd2, 5'd2,  5'd2,  1'b1, 1'b1};
      vecs[4] = '{1'b1, 4'd8, 5'd3,  5'd3,  1'b1, 1'b1};
      vecs[5] = '{1'b0, 4'd0, 5'd0,  5'd1,  1'b0, 1'b0};
      vecs[6] = '{1'b1, 4'hF, 5'd9,  5'd9,  1'b1, 1'b1};
      vecs[7] = '{1'b1, 4'd3, 5'd10, 5'd10, 1'b1, 1'b1};
      vecs[8] = '{1'b1, 4'd1, 5'd0,  5'd0,  1'b0, 1'b0};
      vecs[9] = '{1'b0, 4'd0, 5'd0,  5'd0,  1'b0, 1'b0};

      reset    = 1'b1;
      in_valid = 1'b0;
      stall    = 1'b0;
      sel      = '0;
      in_dst   = '0;
      fwd_addr = '0;
      model_reset();
      step();
      step();
      reset = 1'b0;
      #1;
      check_reset_state("rst");
      check("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         fwd_addr = vecs[i].fwd;
         apply(vecs[i].valid, 1'b0, vecs[i].sel, vecs[i].dst, tag);
         check({tag, "_exp_we"}, {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
         check({tag, "_fwd_hit"}, {31'd0, fwd_hit}, {31'd0, vecs[i].exp_hit});
         check({tag, "_fwd_data"}, fwd_data, vecs[i].exp_hit ? m_data : 32'd0);
      end
      check("hi_value", src[7], 32'hDEAD_BEEF);

      // Accept, then stall for four cycles with a pending request.
      apply(1'b1, 1'b0, 4'd4, 5'd11, "pre_stall");
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 1'b1, 4'd6, 5'd12, $sformatf("stall%0d", i));
      end
      fwd_addr = 5'd12;
      apply(1'b1, 1'b0, 4'd6, 5'd12, "post_stall");
      check("post_stall_fwd", fwd_data, src[6]);
      check("post_stall_cnt", {16'd0, wr_count}, 32'd8);

      // Reset coincident with an accept wins and clears the sticky error.
      in_valid = 1'b1;
      sel      = 4'd5;
      in_dst   = 5'd7;
      reset    = 1'b1;
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      model_reset();
      #1;
      check_reset_state("rst_acc");
      fwd_addr = 5'd7;
      #1;
      check("rst_acc_fwd", {31'd0, fwd_hit}, 32'd0);

      // Preload the write counter to its top value and let one write wrap it.
      force dut.cnt_q = 16'hFFFF;
      #1;
      release dut.cnt_q;
      m_cnt = 16'hFFFF;
      apply(1'b1, 1'b0, 4'd5, 5'd7, "wrap");
      check("wrap_zero", {16'd0, wr_count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
